// File: rtl/sha_ctrl_pkg.sv
// Purpose : shared types and helpers for the SHA message sequencer.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: seq_state_t FSM encoding, DIGEST_CHARS, ASCII_CR/LF, nibble_to_hex().
package sha_ctrl_pkg;

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        FEED      = 2'd1,
        WAIT_HASH = 2'd2,
        SEND      = 2'd3
    } seq_state_t;

    localparam int         DIGEST_CHARS = 64;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    // Lowercase hex: 0-9 -> '0'-'9', 10-15 -> 'a'-'f' ('a' - 10 = 8'h57).
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'd0, n};
        end
        return 8'h57 + {4'd0, n};
    endfunction

endpackage

// File: rtl/sha_msg_sequencer_if.sv
// Purpose : bundle of every non-clock/reset signal of the sequencer.
// Latency : n/a (wiring only).
// Backpr. : tx_busy throttles the TX side, core_delay stalls the feed side.
// Ports   : rx_* from uart_rx, core_* to/from sha256, tx_* to/from uart_tx,
//           msg_len / rx_dropped / timeout_err status.
//           master = sequencer view, slave = surrounding system view.
interface sha_msg_sequencer_if;

    logic         rx_valid;
    logic [7:0]   rx_data;

    logic         core_reset;
    logic [7:0]   core_data;
    logic         core_data_end;
    logic         core_delay;
    logic         core_done;
    logic [255:0] core_hash;

    logic         tx_send;
    logic [7:0]   tx_char;
    logic         tx_busy;

    logic [6:0]   msg_len;
    logic         rx_dropped;
    logic         timeout_err;

    modport master (
        input  rx_valid, rx_data,
        output core_reset, core_data, core_data_end,
        input  core_delay, core_done, core_hash,
        output tx_send, tx_char,
        input  tx_busy,
        output msg_len, rx_dropped, timeout_err
    );

    modport slave (
        output rx_valid, rx_data,
        input  core_reset, core_data, core_data_end,
        output core_delay, core_done, core_hash,
        input  tx_send, tx_char,
        output tx_busy,
        input  msg_len, rx_dropped, timeout_err
    );

endinterface

// File: rtl/msg_byte_buffer.sv
// Purpose : DEPTH x 8 message byte store, one write port and one read port.
// Latency : write lands on the clock edge; read is combinational.
// Backpr. : none; the caller owns all sequencing.
// Ports   : clk, i_we/i_wr_idx/i_wr_dat (write), i_rd_idx -> o_rd_dat (read).
module msg_byte_buffer #(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [7:0]    i_wr_dat,
    input  logic [IW-1:0] i_rd_idx,
    output logic [7:0]    o_rd_dat
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/sha_msg_sequencer.sv
// Purpose : buffers a UART message, feeds it to sha256, streams the digest as hex to uart_tx.
// Latency : first byte on core_data one cycle after terminator/fill; one byte per unstalled cycle.
// Backpr. : core_delay holds the feed; tx_busy gates each character (send held until busy seen).
// Ports   : clk, reset (sync, active-high), bus (sha_msg_sequencer_if.master).
module sha_msg_sequencer
    import sha_ctrl_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] TERMINATOR   = 8'h0D,
    parameter int         HASH_TIMEOUT = 4096,
    parameter bit         APPEND_CRLF  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    sha_msg_sequencer_if.master bus
);

    localparam int         IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         WW          = $clog2(HASH_TIMEOUT) + 1;
    localparam int         TOTAL_CHARS = DIGEST_CHARS + (APPEND_CRLF ? 2 : 0);
    localparam logic [6:0] MAX_LEN7    = 7'(MAX_LEN);
    localparam logic [6:0] LAST_CHAR   = 7'(TOTAL_CHARS - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(HASH_TIMEOUT - 1);

    seq_state_t    r_state;
    logic [6:0]    r_len;
    logic [IW-1:0] r_idx;
    logic [WW-1:0] r_wdog;
    logic [6:0]    r_cnt;
    logic          r_tx_inflight;

    logic          r_core_reset;
    logic [7:0]    r_core_data;
    logic          r_core_data_end;
    logic          r_tx_send;
    logic [7:0]    r_tx_char;
    logic          r_rx_dropped;
    logic          r_timeout_err;

    logic          w_is_term;
    logic          w_wr_en;
    logic [6:0]    w_len_inc;
    logic [IW-1:0] w_rd_idx;
    logic [7:0]    w_rd_dat;
    logic [7:0]    w_first_byte;
    logic [6:0]    w_idx7;
    logic          w_at_last;
    logic          w_next_last;
    logic [7:0]    w_nib_base;
    logic [3:0]    w_nib;
    logic [7:0]    w_char;

    assign w_is_term = (bus.rx_data == TERMINATOR);
    assign w_wr_en   = !reset && (r_state == COLLECT) && bus.rx_valid && !w_is_term;
    assign w_len_inc = r_len + 7'd1;

    // In COLLECT the read port pre-fetches byte 0 for the FEED entry;
    // in FEED it looks one byte ahead of the byte being presented.
    assign w_rd_idx = (r_state == COLLECT) ? '0 : r_idx + IW'(1);

    // A fill with MAX_LEN==1 writes byte 0 on the same edge it must be presented.
    assign w_first_byte = (r_len == 7'd0) ? bus.rx_data : w_rd_dat;

    assign w_idx7      = 7'(r_idx);
    assign w_at_last   = (w_idx7 == r_len - 7'd1);
    assign w_next_last = (w_idx7 + 7'd1 == r_len - 7'd1);

    // Character k shows core_hash[255-4k -: 4]; indices past the digest are CR, LF.
    assign w_nib_base = 8'd255 - {r_cnt[5:0], 2'b00};
    assign w_nib      = bus.core_hash[w_nib_base -: 4];
    always_comb begin
        w_char = nibble_to_hex(w_nib);
        if (r_cnt == 7'(DIGEST_CHARS)) begin
            w_char = ASCII_CR;
        end else if (r_cnt > 7'(DIGEST_CHARS)) begin
            w_char = ASCII_LF;
        end
    end

    msg_byte_buffer #(
        .DEPTH (MAX_LEN),
        .IW    (IW)
    ) u_buf (
        .clk      (clk),
        .i_we     (w_wr_en),
        .i_wr_idx (r_len[IW-1:0]),
        .i_wr_dat (bus.rx_data),
        .i_rd_idx (w_rd_idx),
        .o_rd_dat (w_rd_dat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= COLLECT;
            r_len           <= '0;
            r_idx           <= '0;
            r_wdog          <= '0;
            r_cnt           <= '0;
            r_tx_inflight   <= 1'b0;
            r_core_reset    <= 1'b1;
            r_core_data     <= '0;
            r_core_data_end <= 1'b0;
            r_tx_send       <= 1'b0;
            r_tx_char       <= '0;
            r_rx_dropped    <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            if (bus.rx_valid && (r_state != COLLECT)) begin
                r_rx_dropped <= 1'b1;
            end

            case (r_state)
                COLLECT: begin
                    r_core_reset <= 1'b1;
                    if (bus.rx_valid) begin
                        if (w_is_term) begin
                            if (r_len == 7'd0) begin
                                r_rx_dropped <= 1'b1;
                            end else begin
                                r_state         <= FEED;
                                r_idx           <= '0;
                                r_core_reset    <= 1'b0;
                                r_core_data     <= w_rd_dat;
                                r_core_data_end <= (r_len == 7'd1);
                            end
                        end else begin
                            r_len <= w_len_inc;
                            // Buffer full: start hashing without waiting for a terminator.
                            if (w_len_inc == MAX_LEN7) begin
                                r_state         <= FEED;
                                r_idx           <= '0;
                                r_core_reset    <= 1'b0;
                                r_core_data     <= w_first_byte;
                                r_core_data_end <= (MAX_LEN7 == 7'd1);
                            end
                        end
                    end
                end

                FEED: begin
                    if (!bus.core_delay) begin
                        if (w_at_last) begin
                            r_state         <= WAIT_HASH;
                            r_core_data_end <= 1'b0;
                            r_wdog          <= '0;
                        end else begin
                            r_idx           <= r_idx + IW'(1);
                            r_core_data     <= w_rd_dat;
                            r_core_data_end <= w_next_last;
                        end
                    end
                end

                WAIT_HASH: begin
                    if (bus.core_done) begin
                        r_state       <= SEND;
                        r_cnt         <= '0;
                        r_tx_inflight <= 1'b0;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= COLLECT;
                        r_len         <= '0;
                        r_core_reset  <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end

                SEND: begin
                    if (r_tx_send) begin
                        // Hold request and char until the transmitter acknowledges with busy.
                        if (bus.tx_busy) begin
                            r_tx_send     <= 1'b0;
                            r_tx_inflight <= 1'b1;
                        end
                    end else if (r_tx_inflight) begin
                        if (!bus.tx_busy) begin
                            r_tx_inflight <= 1'b0;
                            if (r_cnt == LAST_CHAR) begin
                                r_state      <= COLLECT;
                                r_len        <= '0;
                                r_core_reset <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 7'd1;
                            end
                        end
                    end else if (!bus.tx_busy) begin
                        r_tx_send <= 1'b1;
                        r_tx_char <= w_char;
                    end
                end

                default: r_state <= COLLECT;
            endcase
        end
    end

    assign bus.core_reset    = r_core_reset;
    assign bus.core_data     = r_core_data;
    assign bus.core_data_end = r_core_data_end;
    assign bus.tx_send       = r_tx_send;
    assign bus.tx_char       = r_tx_char;
    assign bus.msg_len       = r_len;
    assign bus.rx_dropped    = r_rx_dropped;
    assign bus.timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_sha_msg_sequencer.sv
// Purpose : directed self-checking bench for sha_msg_sequencer (MAX_LEN=16, HASH_TIMEOUT=32).
// Latency : inputs driven on negedge, outputs checked on the following negedge.
// Backpr. : a small uart_tx model raises tx_busy for 4 cycles per accepted character.
module tb_sha_msg_sequencer;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam int TOTAL = 66;

    logic clk;
    logic reset;
    sha_msg_sequencer_if bus ();

    sha_msg_sequencer #(
        .MAX_LEN      (16),
        .TERMINATOR   (8'h0D),
        .HASH_TIMEOUT (32),
        .APPEND_CRLF  (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] cap [0:127];
    int         cap_n = 0;
    int         busy_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed still running, required finish");
        $fatal(1);
    end

    // uart_tx model: accepts tx_send when idle, then stays busy for 4 cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_busy) begin
                busy_cnt = busy_cnt - 1;
                if (busy_cnt == 0) bus.tx_busy = 1'b0;
            end else if (bus.tx_send === 1'b1) begin
                if (cap_n < 128) cap[cap_n] = bus.tx_char;
                cap_n        = cap_n + 1;
                busy_cnt     = 4;
                bus.tx_busy  = 1'b1;
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_core_reset"}, bus.core_reset, 1'b1);
        chk8({tag, "_core_data"}, bus.core_data, 8'h00);
        chk1({tag, "_core_end"}, bus.core_data_end, 1'b0);
        chk1({tag, "_tx_send"}, bus.tx_send, 1'b0);
        chk8({tag, "_tx_char"}, bus.tx_char, 8'h00);
        chk8({tag, "_msg_len"}, {1'b0, bus.msg_len}, 8'd0);
        chk1({tag, "_rx_dropped"}, bus.rx_dropped, 1'b0);
        chk1({tag, "_timeout_err"}, bus.timeout_err, 1'b0);
    endtask

    task automatic send_abc(input string tag);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        chk8({tag, "_len3"}, {1'b0, bus.msg_len}, 8'd3);
        send_byte(8'h0D);
    endtask

    // Called on the negedge right after the terminator edge.
    task automatic feed_abc(input string tag, input bit stall);
        chk1({tag, "_core_reset_fall"}, bus.core_reset, 1'b0);
        chk8({tag, "_b0"}, bus.core_data, 8'h61);
        chk1({tag, "_end0"}, bus.core_data_end, 1'b0);
        tick();
        chk8({tag, "_b1"}, bus.core_data, 8'h62);
        chk1({tag, "_end1"}, bus.core_data_end, 1'b0);
        if (stall) begin
            bus.core_delay = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk8({tag, "_b1_hold"}, bus.core_data, 8'h62);
            end
            bus.core_delay = 1'b0;
        end
        tick();
        chk8({tag, "_b2"}, bus.core_data, 8'h63);
        chk1({tag, "_end2"}, bus.core_data_end, 1'b1);
        tick();
        chk1({tag, "_end_clr"}, bus.core_data_end, 1'b0);
    endtask

    task automatic start_hash();
        cap_n         = 0;
        bus.core_hash = ABC_DIGEST;
        bus.core_done = 1'b1;
        tick();
        tick();
        bus.core_done = 1'b0;
    endtask

    task automatic wait_caps(input int n);
        for (int c = 0; c < 3000 && cap_n < n; c++) tick();
    endtask

    task automatic check_digest(input string tag);
        string hex_s;
        hex_s = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
        wait_caps(TOTAL);
        chki({tag, "_char_count"}, cap_n, TOTAL);
        for (int k = 0; k < 64; k++) begin
            chk8({tag, "_hex_char"}, cap[k], hex_s[k]);
        end
        chk8({tag, "_cr"}, cap[64], 8'h0D);
        chk8({tag, "_lf"}, cap[65], 8'h0A);
        repeat (8) tick();
        chki({tag, "_no_extra_char"}, cap_n, TOTAL);
        chk1({tag, "_core_reset_back"}, bus.core_reset, 1'b1);
        chk8({tag, "_len_clr"}, {1'b0, bus.msg_len}, 8'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.core_delay = 1'b0;
        bus.core_done  = 1'b0;
        bus.core_hash  = '0;
        repeat (3) tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();
        chk_reset_vals("post_rst");

        // "abc" + CR, no stall
        send_abc("abc");
        feed_abc("abc", 1'b0);
        chk8("abc_len_wait", {1'b0, bus.msg_len}, 8'd3);
        start_hash();
        check_digest("abc");
        chk1("abc_no_drop", bus.rx_dropped, 1'b0);

        // 16 bytes, no terminator, then watchdog expiry
        cap_n = 0;
        for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
        chk8("fill_len", {1'b0, bus.msg_len}, 8'd16);
        chk1("fill_core_reset", bus.core_reset, 1'b0);
        chk8("fill_b0", bus.core_data, 8'h40);
        for (int j = 1; j < 16; j++) begin
            tick();
            chk8("fill_byte", bus.core_data, 8'h40 + 8'(j));
            chk1("fill_end", bus.core_data_end, (j == 15));
        end
        tick();
        chk1("fill_end_clr", bus.core_data_end, 1'b0);
        repeat (31) tick();
        chk1("wdog_not_yet", bus.timeout_err, 1'b0);
        tick();
        chk1("wdog_expired", bus.timeout_err, 1'b1);
        chk1("wdog_core_reset", bus.core_reset, 1'b1);
        chk8("wdog_len_clr", {1'b0, bus.msg_len}, 8'd0);
        repeat (4) tick();
        chki("wdog_no_tx", cap_n, 0);

        // lone terminator is dropped
        send_byte(8'h0D);
        chk1("lone_cr_drop", bus.rx_dropped, 1'b1);
        chk8("lone_cr_len", {1'b0, bus.msg_len}, 8'd0);
        chk1("lone_cr_core_reset", bus.core_reset, 1'b1);

        // "abc" with a 3-cycle stall on byte 1, plus a byte during SEND
        send_abc("stall");
        feed_abc("stall", 1'b1);
        start_hash();
        wait_caps(1);
        send_byte(8'h78);
        chk1("send_x_drop", bus.rx_dropped, 1'b1);
        chk8("send_x_len", {1'b0, bus.msg_len}, 8'd3);
        check_digest("stall");

        // reset during the digest stream, then a clean message
        send_abc("rstmid");
        feed_abc("rstmid", 1'b0);
        start_hash();
        wait_caps(11);
        chki("rstmid_reached_char10", (cap_n >= 11) ? 1 : 0, 1);
        reset = 1'b1;
        tick();
        chk_reset_vals("rstmid");
        reset = 1'b0;
        repeat (6) tick();
        send_abc("after_rst");
        feed_abc("after_rst", 1'b0);
        start_hash();
        check_digest("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
